// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and helpers for the block-RAM write-port arbiter.
// Holds the arbitration state encoding, the burst counter width and a constant clog2.
package bram_port_arbiter_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int unsigned BURST_CNT_W = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side and RAM write-port signals of the arbiter, bundled as one interface.
// slave = arbiter side, master = client/RAM environment side.
interface bram_port_arbiter_if #(
  parameter int unsigned D_SIZE  = 64,
  parameter int unsigned Q_DEPTH = 8,
  parameter int unsigned N_REQ   = 4
);

  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         lock;
  logic [N_REQ-1:0]         we;
  logic [N_REQ*Q_DEPTH-1:0] addr;
  logic [N_REQ*D_SIZE-1:0]  din;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         rvalid;
  logic [D_SIZE-1:0]        rdata;
  logic                     bram_wr_en;
  logic [Q_DEPTH-1:0]       bram_wr_addr;
  logic [D_SIZE-1:0]        bram_wr_din;
  logic [D_SIZE-1:0]        bram_wr_dout;

  modport slave (
    input  req, lock, we, addr, din, bram_wr_dout,
    output gnt, rvalid, rdata, bram_wr_en, bram_wr_addr, bram_wr_din
  );

  modport master (
    output req, lock, we, addr, din, bram_wr_dout,
    input  gnt, rvalid, rdata, bram_wr_en, bram_wr_addr, bram_wr_din
  );

endinterface

// File: rtl/bram_port_arbiter_rr_pick.sv
// Rotating-priority pick: first set request at or above ptr_i, wrapping modulo N_REQ.
// Returns the winner as one-hot and as an index, plus a valid flag.
module bram_port_arbiter_rr_pick
  import bram_port_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned PW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PW-1:0]    idx_o,
  output logic             vld_o
);

  always_comb begin
    int unsigned c;
    c     = 0;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      c = (int'(ptr_i) + k) % N_REQ;
      if (!vld_o && req_i[c]) begin
        vld_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = PW'(c);
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter for the shared write/read-back port of the block RAM, with
// lock-driven bursts of up to MAX_BURST beats and a one-cycle registered return path.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned D_SIZE    = 64,
  parameter int unsigned Q_DEPTH   = 8,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                rst,
  bram_port_arbiter_if.slave  bus
);

  localparam int unsigned PW = clog2(N_REQ);
  localparam logic [BURST_CNT_W:0] BURST_LAST = (BURST_CNT_W+1)'(MAX_BURST);
  localparam bit BURSTS_ON = (MAX_BURST > 1);

  arb_state_e             state_q, state_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]          owner_q, owner_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [N_REQ-1:0]       rvalid_q, rvalid_d;

  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]    win_idx;
  logic             accept;
  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             pick_vld;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
    return (i == PW'(N_REQ-1)) ? '0 : i + 1'b1;
  endfunction

  bram_port_arbiter_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i (bus.req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    gnt         = '0;
    win_idx     = '0;

    case (state_q)
      ARB: begin
        if (pick_vld) begin
          gnt     = pick_gnt;
          win_idx = pick_idx;
        end
      end
      HOLD: begin
        gnt     = N_REQ'(1) << owner_q;
        win_idx = owner_q;
      end
      default: ;
    endcase

    // Grant is combinational, so it must be masked directly while reset is held.
    if (rst) gnt = '0;

    accept   = |(bus.req & gnt);
    rvalid_d = bus.req & gnt;

    if (accept) rr_ptr_d = wrap_inc(win_idx);

    case (state_q)
      ARB: begin
        if (accept && bus.lock[win_idx] && BURSTS_ON) begin
          state_d     = HOLD;
          owner_d     = win_idx;
          burst_cnt_d = BURST_CNT_W'(1);
        end
      end
      HOLD: begin
        // In HOLD no accept means the owner dropped req; that also ends the burst.
        if (accept && bus.lock[owner_q]) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (({1'b0, burst_cnt_q} + 1'b1) == BURST_LAST) state_d = ARB;
        end else begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      rvalid_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign bus.gnt          = gnt;
  assign bus.rvalid       = rvalid_q;
  assign bus.rdata        = bus.bram_wr_dout;
  assign bus.bram_wr_en   = accept & bus.we[win_idx];
  assign bus.bram_wr_addr = accept ? bus.addr[int'(win_idx)*Q_DEPTH +: Q_DEPTH] : '0;
  assign bus.bram_wr_din  = accept ? bus.din[int'(win_idx)*D_SIZE +: D_SIZE] : '0;

endmodule
